// File: rtl/imem_loader.sv
// imem_loader -- debug-unit program download sequencer for the instruction memory.
//
// Collects UART bytes (MSB first) into 32-bit words. Each word goes to the
// instruction memory write port at sequential word addresses. The CPU
// pipeline is held for the whole download. The memory address port returns
// to the fetch PC once the download is finished.
//
// Parameters:
//   ADDR_W          word-address width, memory depth = 2**ADDR_W words
//   HALT_WORD       end-of-program marker (written, then the load ends)
//   TIMEOUT_CYCLES  inter-byte timeout in clk cycles (timeout build only)
//
// Ports:
//   clk, rst    clock; asynchronous active-high reset
//   start_load  one-cycle pulse: begin a download (honoured only in IDLE)
//   rx_valid    one-cycle pulse: rx_data holds a received byte
//   rx_data     received byte
//   pc_addr     fetch address, passed to imem_addr while idle
//   imem_addr   memory address: pc_addr in IDLE, else zero-extended load address
//   imem_wdata  assembled word (registered)
//   imem_wr     one-cycle memory write strobe (registered)
//   cpu_hold    pipeline stall, high in LOAD and DONE
//   busy        high in LOAD
//   done        one-cycle pulse on load completion
//   word_count  words written by the last or current load (saturates at depth)
//   error       sticky inter-byte timeout flag, cleared by start_load
//
// Build option: define IMEM_LOADER_TIMEOUT_EN to enable the inter-byte
// timeout. When it is not defined, error is tied low.

module imem_loader #(
    parameter int          ADDR_W         = 5,
    parameter logic [31:0] HALT_WORD      = 32'hFFFF_FFFF,
    parameter int          TIMEOUT_CYCLES = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_load,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    input  logic [31:0]       pc_addr,
    output logic [31:0]       imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              imem_wr,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   word_count,
    output logic              error
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // word_count value for a completely filled memory (DEPTH)
    localparam logic [ADDR_W:0] FULL_COUNT = {1'b1, {ADDR_W{1'b0}}};

    if (TIMEOUT_CYCLES < 1) begin : gBadTimeout
        $error("imem_loader: TIMEOUT_CYCLES must be at least 1");
    end

    logic [1:0]        state;
    logic [ADDR_W-1:0] loadAddr;
    logic [1:0]        byteCnt;
    // The first three bytes of the word being assembled. The fourth byte
    // completes the word directly from rx_data.
    logic [23:0]       wordBuf;

`ifdef IMEM_LOADER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] idleTimer;
    logic          errorReg;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            loadAddr   <= '0;
            byteCnt    <= '0;
            wordBuf    <= '0;
            imem_wdata <= '0;
            imem_wr    <= 1'b0;
            word_count <= '0;
`ifdef IMEM_LOADER_TIMEOUT_EN
            idleTimer  <= '0;
            errorReg   <= 1'b0;
`endif
        end else begin
            imem_wr <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_load) begin
                        state      <= LOAD;
                        loadAddr   <= '0;
                        byteCnt    <= '0;
                        word_count <= '0;
`ifdef IMEM_LOADER_TIMEOUT_EN
                        idleTimer  <= '0;
                        errorReg   <= 1'b0;
`endif
                    end
                end

                LOAD: begin
                    // A byte is accepted even during the write cycle. It becomes
                    // byte 0 of the next word, so back-to-back bytes are never lost.
                    if (rx_valid) begin
                        wordBuf <= {wordBuf[15:0], rx_data};
                        byteCnt <= byteCnt + 2'd1;
                        if (byteCnt == 2'd3) begin
                            imem_wdata <= {wordBuf, rx_data};
                            imem_wr    <= 1'b1;
                        end
                    end

                    // The write cycle: advance the address after the memory
                    // has seen it. Stop at the halt marker or at the last
                    // word, so the address never wraps.
                    if (imem_wr) begin
                        if (word_count != FULL_COUNT)
                            word_count <= word_count + (ADDR_W+1)'(1);
                        if (imem_wdata == HALT_WORD || loadAddr == '1)
                            state <= DONE;
                        else
                            loadAddr <= loadAddr + ADDR_W'(1);
                    end

`ifdef IMEM_LOADER_TIMEOUT_EN
                    // The timer only runs while a word is partially assembled.
                    if (rx_valid) begin
                        idleTimer <= '0;
                    end else if (byteCnt != 2'd0) begin
                        if (idleTimer == TW'(TIMEOUT_CYCLES - 1)) begin
                            errorReg  <= 1'b1;
                            byteCnt   <= '0;
                            idleTimer <= '0;
                            state     <= IDLE;
                        end else begin
                            idleTimer <= idleTimer + TW'(1);
                        end
                    end
`endif
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        imem_addr = pc_addr;
        if (state != IDLE)
            imem_addr = {{(32-ADDR_W){1'b0}}, loadAddr};
    end

    assign cpu_hold = (state == LOAD) || (state == DONE);
    assign busy     = (state == LOAD);
    assign done     = (state == DONE);

`ifdef IMEM_LOADER_TIMEOUT_EN
    assign error = errorReg;
`else
    assign error = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader -- self-checking bench for imem_loader.
//
// The bench has a reference model that turns each planned byte stream into
// the list of (address, word) writes the memory must receive. A compare
// process checks every write strobe, every done pulse and the fetch
// pass-through against that model on each negedge. Directed checks with
// literal values pin the reset state, the latency and the boundary cases.

module tb_imem_loader;

    localparam int          ADDR_W = 5;
    localparam int          DEPTH  = 2**ADDR_W;
    localparam logic [31:0] HALT   = 32'hFFFF_FFFF;

    logic              clk;
    logic              rst;
    logic              start_load;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic [31:0]       pc_addr;
    logic [31:0]       imem_addr;
    logic [31:0]       imem_wdata;
    logic              imem_wr;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic [ADDR_W:0]   word_count;
    logic              error;

    imem_loader #(
        .ADDR_W         (ADDR_W),
        .HALT_WORD      (HALT),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start_load (start_load),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .pc_addr    (pc_addr),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .imem_wr    (imem_wr),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .word_count (word_count),
        .error      (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nChecks  = 0;
    int nFails   = 0;
    int doneSeen = 0;
    int doneMark;
    int nw;

    logic [31:0] expAddr[$];
    logic [31:0] expData[$];
    logic [7:0]  stim[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: splits the byte stream into MSB-first words at addresses
    // 0,1,2,... The load ends after the halt word or after the last word of
    // the memory. Any trailing bytes produce no write.
    task automatic modelLoad(output int nWords);
        logic [31:0] w;
        int a;
        a = 0;
        nWords = 0;
        for (int i = 0; i + 3 < stim.size(); i += 4) begin
            w = {stim[i], stim[i+1], stim[i+2], stim[i+3]};
            expAddr.push_back(32'(a));
            expData.push_back(w);
            nWords++;
            if (w == HALT || a == DEPTH - 1) break;
            a++;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sendByte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick(1);
        rx_valid = 1'b0;
    endtask

    task automatic sendRange(input int from, input int upto, input int gap);
        for (int i = from; i < upto; i++) begin
            sendByte(stim[i]);
            tick(gap);
        end
    endtask

    task automatic startLoad();
        start_load = 1'b1;
        tick(1);
        start_load = 1'b0;
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (!rst) begin
            if (imem_wr) begin
                if (expAddr.size() == 0) begin
                    chk("spurious_wr", {31'b0, imem_wr}, 32'd0);
                end else begin
                    chk("wr_addr", imem_addr, expAddr.pop_front());
                    chk("wr_data", imem_wdata, expData.pop_front());
                end
            end
            if (done) begin
                doneSeen++;
                chk("done_hold", {31'b0, cpu_hold}, 32'd1);
                chk("done_busy", {31'b0, busy}, 32'd0);
            end
            if (!cpu_hold)
                chk("pc_pass", imem_addr, pc_addr);
        end
    end

    initial begin
        // 1: reset state and fetch pass-through
        rst = 1'b1; start_load = 1'b0; rx_valid = 1'b0; rx_data = '0; pc_addr = 32'd7;
        #2;
        chk("rst_wr",    {31'b0, imem_wr}, 32'd0);
        chk("rst_wdata", imem_wdata, 32'd0);
        chk("rst_hold",  {31'b0, cpu_hold}, 32'd0);
        chk("rst_busy",  {31'b0, busy}, 32'd0);
        chk("rst_done",  {31'b0, done}, 32'd0);
        chk("rst_wcnt",  32'(word_count), 32'd0);
        chk("rst_err",   {31'b0, error}, 32'd0);
        chk("rst_addr7", imem_addr, 32'd7);
        pc_addr = 32'd9;
        #1;
        chk("rst_addr9", imem_addr, 32'd9);
        tick(2);
        rst = 1'b0;
        tick(1);

        // 2: three-word program ending in the halt word
        stim = '{8'h00, 8'h22, 8'h18, 8'h20, 8'h00, 8'h22, 8'h20, 8'h22,
                 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        modelLoad(nw);
        doneMark = doneSeen;
        startLoad();
        chk("ld_busy", {31'b0, busy}, 32'd1);
        chk("ld_hold", {31'b0, cpu_hold}, 32'd1);
        chk("ld_addr0", imem_addr, 32'd0);
        sendRange(0, 4, 0);
        chk("lat_wr",   {31'b0, imem_wr}, 32'd1);
        chk("lat_data", imem_wdata, 32'h0022_1820);
        chk("lat_addr", imem_addr, 32'd0);
        chk("lat_wcnt", 32'(word_count), 32'd0);
        tick(1);
        chk("post_wr",   {31'b0, imem_wr}, 32'd0);
        chk("post_wcnt", 32'(word_count), 32'd1);
        chk("post_addr", imem_addr, 32'd1);
        sendRange(4, 8, 1);
        sendRange(8, 12, 0);
        chk("halt_data", imem_wdata, 32'hFFFF_FFFF);
        chk("halt_addr", imem_addr, 32'd2);
        tick(1);
        chk("dn_done", {31'b0, done}, 32'd1);
        chk("dn_hold", {31'b0, cpu_hold}, 32'd1);
        chk("dn_wcnt", 32'(word_count), 32'd3);
        start_load = 1'b1;              // ignored in DONE
        tick(1);
        start_load = 1'b0;
        chk("idle_busy", {31'b0, busy}, 32'd0);
        chk("idle_hold", {31'b0, cpu_hold}, 32'd0);
        chk("idle_done", {31'b0, done}, 32'd0);
        chk("s2_donecnt", 32'(doneSeen - doneMark), 32'd1);
        tick(3);
        chk("s2_wcnt_hold", 32'(word_count), 32'd3);
        chk("s2_drained", 32'(expAddr.size()), 32'd0);

        // 3: full depth without the halt word; trailing bytes are dropped
        stim.delete();
        for (int i = 0; i < 4 * DEPTH + 8; i++) stim.push_back(8'(i));
        modelLoad(nw);
        doneMark = doneSeen;
        startLoad();
        sendRange(0, stim.size(), 0);
        tick(5);
        chk("full_wcnt", 32'(word_count), 32'd32);
        chk("full_donecnt", 32'(doneSeen - doneMark), 32'd1);
        chk("full_busy", {31'b0, busy}, 32'd0);
        chk("full_drained", 32'(expAddr.size()), 32'd0);

        // 4: reset in the middle of a write cycle, then after a partial word
        stim = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
        modelLoad(nw);
        stim = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hB1, 8'hB2, 8'hB3, 8'hB4};
        startLoad();
        sendRange(0, 8, 0);
        chk("mid_wr_before", {31'b0, imem_wr}, 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_wr_after", {31'b0, imem_wr}, 32'd0);
        chk("mid_busy", {31'b0, busy}, 32'd0);
        chk("mid_addr", imem_addr, pc_addr);
        chk("mid_wcnt", 32'(word_count), 32'd0);
        tick(2);
        rst = 1'b0;
        tick(1);
        startLoad();
        sendByte(8'hC1);
        sendByte(8'hC2);
        rst = 1'b1;
        #1;
        chk("part_busy", {31'b0, busy}, 32'd0);
        tick(1);
        rst = 1'b0;
        tick(1);
        stim = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        modelLoad(nw);
        startLoad();
        sendRange(0, 8, 1);
        tick(3);
        chk("fresh_wcnt", 32'(word_count), 32'd2);
        chk("fresh_drained", 32'(expAddr.size()), 32'd0);

        // 5: ignored inputs and a byte coincident with the write strobe
        stim = '{8'h01, 8'h02, 8'h03, 8'h04};
        sendRange(0, 4, 0);             // in IDLE: no write allowed
        tick(2);
        chk("idle_rx_busy", {31'b0, busy}, 32'd0);
        chk("idle_rx_wcnt", 32'(word_count), 32'd2);
        stim = '{8'h5A, 8'h01, 8'h02, 8'h03, 8'hA5, 8'hB6, 8'hC7, 8'hD8,
                 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        modelLoad(nw);
        doneMark = doneSeen;
        startLoad();
        sendRange(0, 2, 0);
        start_load = 1'b1;              // ignored in LOAD
        tick(1);
        start_load = 1'b0;
        chk("ign_busy", {31'b0, busy}, 32'd1);
        sendRange(2, 8, 0);
        chk("coin_data", imem_wdata, 32'hA5B6_C7D8);
        chk("coin_addr", imem_addr, 32'd1);
        sendRange(8, 12, 0);
        tick(3);
        chk("s5_wcnt", 32'(word_count), 32'd3);
        chk("s5_donecnt", 32'(doneSeen - doneMark), 32'd1);
        chk("s5_drained", 32'(expAddr.size()), 32'd0);

`ifdef IMEM_LOADER_TIMEOUT_EN
        // 6: inter-byte timeout after a partial word
        doneMark = doneSeen;
        startLoad();
        sendByte(8'h12);
        sendByte(8'h34);
        tick(99);
        chk("to_err_early", {31'b0, error}, 32'd0);
        chk("to_busy_early", {31'b0, busy}, 32'd1);
        tick(1);
        chk("to_err", {31'b0, error}, 32'd1);
        chk("to_busy", {31'b0, busy}, 32'd0);
        chk("to_hold", {31'b0, cpu_hold}, 32'd0);
        tick(3);
        chk("to_sticky", {31'b0, error}, 32'd1);
        chk("to_donecnt", 32'(doneSeen - doneMark), 32'd0);
        chk("to_wcnt", 32'(word_count), 32'd0);
        stim = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
        modelLoad(nw);
        startLoad();
        chk("to_clear", {31'b0, error}, 32'd0);
        sendRange(0, 4, 0);
        tick(3);
        chk("to_after_wcnt", 32'(word_count), 32'd1);
`else
        tick(2);
        chk("err_tied", {31'b0, error}, 32'd0);
`endif

        chk("final_drained", 32'(expAddr.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
